// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port main memory.
// The arbiter takes the slave view; requesters and the memory model take the master view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              ack0;
    logic [DATA_W-1:0] rdata0;
    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              ack1;
    logic [DATA_W-1:0] rdata1;
    logic              gnt0;
    logic              gnt1;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
        output ack0, rdata0, ack1, rdata1, gnt0, gnt1,
        output mem_addr, mem_wdata, mem_we, mem_re, busy
    );

    modport master (
        output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
        input  ack0, rdata0, ack1, rdata1, gnt0, gnt1,
        input  mem_addr, mem_wdata, mem_we, mem_re, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing a single-port memory (1-cycle registered read) between
// the CPU (port 0) and the loader (port 1); each access runs IDLE -> ISSUE -> RESP.
module mem_port_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input logic              clk,
    input logic              n_reset,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t            state;
    state_t            nextState;
    logic              win;
    logic              winner;
    logic              lastGrant;
    logic              curPort;
    logic              curWe;
    logic [ADDR_W-1:0] curAddr;
    logic [DATA_W-1:0] curWdata;
    logic [DATA_W-1:0] rdata0Q;
    logic [DATA_W-1:0] rdata1Q;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // On a tie the port that did not win last time goes first.
    always_comb begin
        nextState = state;
        win       = 1'b0;
        winner    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    win       = 1'b1;
                    winner    = (bus.req0 && bus.req1) ? ~lastGrant : bus.req1;
                    nextState = ISSUE;
                end
            end
            ISSUE:   nextState = RESP;
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            lastGrant <= 1'b1;
            curPort   <= 1'b0;
            curWe     <= 1'b0;
            curAddr   <= '0;
            curWdata  <= '0;
            rdata0Q   <= '0;
            rdata1Q   <= '0;
        end else begin
            if (win) begin
                lastGrant <= winner;
                curPort   <= winner;
                curWe     <= winner ? bus.we1    : bus.we0;
                curAddr   <= winner ? bus.addr1  : bus.addr0;
                curWdata  <= winner ? bus.wdata1 : bus.wdata0;
            end
            if (state == RESP && !curWe) begin
                if (curPort) begin
                    rdata1Q <= bus.mem_rdata;
                end else begin
                    rdata0Q <= bus.mem_rdata;
                end
            end
        end
    end

    // Read data is forwarded from the memory during RESP so it is valid alongside ack.
    always_comb begin
        bus.busy      = (state != IDLE);
        bus.gnt0      = (state != IDLE) && !curPort;
        bus.gnt1      = (state != IDLE) &&  curPort;
        bus.ack0      = (state == RESP) && !curPort;
        bus.ack1      = (state == RESP) &&  curPort;
        bus.mem_we    = (state == ISSUE) &&  curWe;
        bus.mem_re    = (state == ISSUE) && !curWe;
        bus.mem_addr  = curAddr;
        bus.mem_wdata = curWdata;
        bus.rdata0    = rdata0Q;
        bus.rdata1    = rdata1Q;
        if (state == RESP && !curWe) begin
            if (curPort) begin
                bus.rdata1 = bus.mem_rdata;
            end else begin
                bus.rdata0 = bus.mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: memory model, directed scenarios and a randomized phase
// checked against a shadow memory and the round-robin rule.
module tb_mem_port_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;

    logic clk     = 1'b0;
    logic n_reset = 1'b1;

    int compared   = 0;
    int mismatched = 0;

    logic [DW-1:0] memArr [256];
    logic [DW-1:0] refMem [256];
    logic [DW-1:0] expRdata [2];
    int            lastServed;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Single-port memory with registered read data.
    always @(posedge clk) begin
        if (bus.mem_we) memArr[bus.mem_addr] = bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= memArr[bus.mem_addr];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic ackOf(input int p);
        return (p != 0) ? bus.ack1 : bus.ack0;
    endfunction

    function automatic logic gntOf(input int p);
        return (p != 0) ? bus.gnt1 : bus.gnt0;
    endfunction

    function automatic logic [DW-1:0] rdataOf(input int p);
        return (p != 0) ? bus.rdata1 : bus.rdata0;
    endfunction

    task automatic drive(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin
            bus.req0 = 1'b1; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
        end else begin
            bus.req1 = 1'b1; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
        end
    endtask

    task automatic dropReq(input int p);
        if (p == 0) bus.req0 = 1'b0;
        else        bus.req1 = 1'b0;
    endtask

    task automatic doReset();
        n_reset  = 1'b0;
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
        #1;
        check("reset_ctrl", {bus.ack0, bus.ack1, bus.gnt0, bus.gnt1, bus.mem_we, bus.mem_re, bus.busy}, 0);
        check("reset_mem_addr", bus.mem_addr, 0);
        check("reset_mem_wdata", bus.mem_wdata, 0);
        check("reset_rdata0", bus.rdata0, 0);
        check("reset_rdata1", bus.rdata1, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_reset     = 1'b1;
        expRdata[0] = '0;
        expRdata[1] = '0;
        lastServed  = 1;
    endtask

    // Caller has port p's request up while the DUT is (or next edge will be) idle.
    task automatic serve(input int p, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input bit mutate);
        @(posedge clk); @(negedge clk);
        check("issue_gnt", gntOf(p), 1);
        check("issue_gnt_other", gntOf(1 - p), 0);
        check("issue_we", bus.mem_we, w);
        check("issue_re", bus.mem_re, !w);
        check("issue_addr", bus.mem_addr, a);
        if (w) check("issue_wdata", bus.mem_wdata, d);
        check("issue_busy", bus.busy, 1);
        check("issue_ack", {bus.ack0, bus.ack1}, 0);
        if (mutate) begin
            bus.addr0  = a + 8'd10;
            bus.wdata0 = ~d;
            bus.we0    = ~w;
            #1;
            check("issue_addr_stable", bus.mem_addr, a);
            check("issue_re_stable", bus.mem_re, !w);
        end
        @(posedge clk); @(negedge clk);
        if (w) refMem[a] = d;
        else   expRdata[p] = refMem[a];
        check("resp_ack", ackOf(p), 1);
        check("resp_ack_other", ackOf(1 - p), 0);
        check("resp_gnt", gntOf(p), 1);
        check("resp_strobes", {bus.mem_we, bus.mem_re}, 0);
        check("resp_rdata", rdataOf(p), expRdata[p]);
        check("resp_rdata_other", rdataOf(1 - p), expRdata[1 - p]);
        lastServed = p;
        @(posedge clk); #1;
        dropReq(p);
        @(negedge clk);
        check("idle_ack", ackOf(p), 0);
        check("idle_busy", bus.busy, 0);
        check("idle_rdata_hold", rdataOf(p), expRdata[p]);
    endtask

    initial begin
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        logic          w0, w1;
        int            p, first;

        for (int i = 0; i < 256; i++) begin
            memArr[i] = $urandom;
            refMem[i] = memArr[i];
        end
        memArr[5]  = 32'h1234_5678; refMem[5]  = 32'h1234_5678;
        memArr[10] = 32'hAAAA_0010; refMem[10] = 32'hAAAA_0010;
        memArr[20] = 32'hBBBB_0020; refMem[20] = 32'hBBBB_0020;

        // Basic read, write, and read-back.
        doReset();
        drive(0, 1'b0, 8'h05, '0);
        serve(0, 1'b0, 8'h05, '0, 1'b0);
        check("read5_value", bus.rdata0, 32'h1234_5678);
        drive(1, 1'b1, 8'hFF, 32'hDEAD_BEEF);
        serve(1, 1'b1, 8'hFF, 32'hDEAD_BEEF, 1'b0);
        drive(0, 1'b0, 8'hFF, '0);
        serve(0, 1'b0, 8'hFF, '0, 1'b0);
        check("readFF_value", bus.rdata0, 32'hDEAD_BEEF);

        // Both ports requesting continuously from reset: alternate 0,1,0,1 every 3 cycles.
        n_reset = 1'b0;
        a0 = 8'h05; a1 = 8'h0A;
        #1;
        drive(0, 1'b0, a0, '0);
        drive(1, 1'b0, a1, '0);
        @(posedge clk); @(negedge clk);
        n_reset = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); @(negedge clk);
            check("rr_ack0", bus.ack0, (k % 3 == 2) && (((k - 2) / 3) % 2 == 0));
            check("rr_ack1", bus.ack1, (k % 3 == 2) && (((k - 2) / 3) % 2 == 1));
            check("rr_gnt_excl", bus.gnt0 && bus.gnt1, 0);
            check("rr_strobe_excl", bus.mem_we && bus.mem_re, 0);
            if (k == 11) begin
                check("rr_rdata0", bus.rdata0, refMem[a0]);
                check("rr_rdata1", bus.rdata1, refMem[a1]);
            end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        expRdata[0] = refMem[a0]; expRdata[1] = refMem[a1]; lastServed = 1;

        // Reset during ISSUE of a port 0 write: strobe drops at once, no ack, tie then goes to port 0.
        @(posedge clk); @(negedge clk);
        drive(0, 1'b1, 8'h33, 32'hCAFE_F00D);
        @(posedge clk); @(negedge clk);
        check("abort_we_before", bus.mem_we, 1);
        #1 n_reset = 1'b0;
        #1;
        check("abort_we_dropped", bus.mem_we, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_gnt0", bus.gnt0, 0);
        bus.req0 = 1'b0;
        @(posedge clk); @(negedge clk);
        check("abort_no_ack", {bus.ack0, bus.ack1}, 0);
        @(posedge clk); @(negedge clk);
        n_reset = 1'b1;
        expRdata[0] = '0; expRdata[1] = '0; lastServed = 1;
        drive(0, 1'b0, 8'h33, '0);
        drive(1, 1'b0, 8'h44, '0);
        serve(0, 1'b0, 8'h33, '0, 1'b0);
        serve(1, 1'b0, 8'h44, '0, 1'b0);

        // Back-to-back port 0 reads; port 1 stays idle so rdata1 stays 0.
        doReset();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1'b0, AW'(i), '0);
            serve(0, 1'b0, AW'(i), '0, 1'b0);
            check("b2b_rdata1_zero", bus.rdata1, 0);
        end

        // Request inputs changed after the win do not affect the access.
        drive(0, 1'b0, 8'd10, '0);
        serve(0, 1'b0, 8'd10, '0, 1'b1);
        check("mutate_rdata0", bus.rdata0, 32'hAAAA_0010);

        // Randomized single and contending accesses.
        for (int it = 0; it < 40; it++) begin
            a0 = AW'($urandom); a1 = AW'($urandom);
            d0 = $urandom;      d1 = $urandom;
            w0 = 1'($urandom);  w1 = 1'($urandom);
            if ($urandom_range(0, 3) != 3) begin
                p = int'($urandom_range(0, 1));
                if (p == 0) begin
                    drive(0, w0, a0, d0);
                    serve(0, w0, a0, d0, 1'b0);
                end else begin
                    drive(1, w1, a1, d1);
                    serve(1, w1, a1, d1, 1'b0);
                end
            end else begin
                drive(0, w0, a0, d0);
                drive(1, w1, a1, d1);
                first = 1 - lastServed;
                if (first == 0) begin
                    serve(0, w0, a0, d0, 1'b0);
                    serve(1, w1, a1, d1, 1'b0);
                end else begin
                    serve(1, w1, a1, d1, 1'b0);
                    serve(0, w0, a0, d0, 1'b0);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
